// File: rtl/spike_input_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_input_queue_if
// Description : Spike event handshake between producers, the input queue and
//               the network controller.
// Revision    : 1.0
// ============================================================================
interface spike_input_queue_if #(
    parameter int SR_DEPTH = 16384
);
    localparam int IW = $clog2(SR_DEPTH);

    logic          push_valid;
    logic [IW-1:0] push_index;
    logic          push_ready;
    logic          input_occurred;
    logic [IW-1:0] input_index;
    logic          input_ack;

    // Queue side
    modport slave (
        input  push_valid,
        input  push_index,
        output push_ready,
        output input_occurred,
        output input_index,
        input  input_ack
    );

    // Producer/controller side
    modport master (
        output push_valid,
        output push_index,
        input  push_ready,
        input  input_occurred,
        input  input_index,
        output input_ack
    );
endinterface
`default_nettype wire

// File: rtl/spike_input_queue.sv
`default_nettype none
// ============================================================================
// Module      : spike_input_queue
// Description : FIFO of presynaptic spike events presented to the controller
//               one at a time with an ack handshake. Optional statistics
//               counters enabled by SPIKE_QUEUE_STATS_EN.
// Revision    : 1.0
// ============================================================================
module spike_input_queue #(
    parameter int SR_DEPTH    = 16384,
    parameter int QUEUE_DEPTH = 16      // power of two, >= 2
) (
    input  logic                           clk,
    input  logic                           reset,
    spike_input_queue_if.slave             bus,
    output logic [$clog2(QUEUE_DEPTH):0]   level,
    output logic                           overflow,
    input  logic                           clear_overflow
`ifdef SPIKE_QUEUE_STATS_EN
    ,
    output logic [15:0]                    sent_count,
    output logic [15:0]                    drop_count
`endif
);
    localparam int IW = $clog2(SR_DEPTH);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0] c_ptr_one = PW'(1);
    localparam logic [LW-1:0] c_cnt_one = LW'(1);
    localparam logic [LW-1:0] c_full    = LW'(QUEUE_DEPTH);

    logic [IW-1:0] r_mem [QUEUE_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [LW-1:0] r_count;
    logic          r_overflow;

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_not_empty;

    assign w_not_empty = (r_count != '0);
    // A pop frees the slot in the same edge, so a full queue still accepts
    // a push when the controller acks.
    assign w_pop          = bus.input_ack & w_not_empty;
    assign bus.push_ready = (r_count != c_full) | w_pop;
    assign w_push         = bus.push_valid & bus.push_ready;
    assign w_drop         = bus.push_valid & ~bus.push_ready;

    assign bus.input_occurred = w_not_empty;
    assign bus.input_index    = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign level              = r_count;
    assign overflow           = r_overflow;

    // Storage is not reset so it can map onto RAM; the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.push_index;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef SPIKE_QUEUE_STATS_EN
    logic [15:0] r_sent;
    logic [15:0] r_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            if (w_pop) begin
                if (r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
            end else if (clear_overflow) begin
                r_sent <= '0;
            end
            if (w_drop) begin
                if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            end else if (clear_overflow) begin
                r_drop <= '0;
            end
        end
    end

    assign sent_count = r_sent;
    assign drop_count = r_drop;
`endif
endmodule
`default_nettype wire
